// File: rtl/obstacle_frame_scheduler.sv
// Per-frame sequencer: strobes the obstacle shift bank, then paints every cell as a 4x4 block on the VGA port.
// Build option: define OVERRUN_CNT_EN to implement the saturating overrun_count register (tied to 0 otherwise).
module obstacle_frame_scheduler #(
  parameter int         COLS      = 40,
  parameter int         ROWS      = 30,
  parameter int         ORIGIN_X  = 156,
  parameter int         ORIGIN_Y  = 0,
  parameter logic [2:0] FG_COLOUR = 3'b011,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic [COLS*ROWS-1:0] cell_data,
  input  logic                 vga_grant,
  output logic                 shift_en,
  output logic                 plot_req,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun,
  output logic [7:0]           overrun_count
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int IDX_W = $clog2(COLS*ROWS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SHIFT  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DRAW   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state;
  logic [3:0]       px_p0;
  logic [COL_W-1:0] col_p0;
  logic [ROW_W-1:0] row_p0;
  logic [3:0]       px_nxt;
  logic [COL_W-1:0] col_nxt;
  logic [ROW_W-1:0] row_nxt;
  logic             last_px;
  logic [3:0]       tgt_px;
  logic [COL_W-1:0] tgt_col;
  logic [ROW_W-1:0] tgt_row;
  logic [IDX_W-1:0] cell_idx;
  logic             accept;
  logic             tick_busy;

  // Columns run right-to-left on screen, so x wraps naturally modulo 256.
  function automatic logic [7:0] pix_x(input logic [COL_W-1:0] c, input logic [3:0] p);
    pix_x = 8'(ORIGIN_X) + 8'(p[3:2]) - (8'(c) << 2);
  endfunction

  function automatic logic [6:0] pix_y(input logic [ROW_W-1:0] r, input logic [3:0] p);
    pix_y = 7'(ORIGIN_Y) + 7'(p[1:0]) + (7'(r) << 2);
  endfunction

  function automatic logic [2:0] pick_colour(input logic set);
    pick_colour = set ? FG_COLOUR : BG_COLOUR;
  endfunction

  assign accept    = plot_req && vga_grant;
  assign tick_busy = frame_tick && (state != S_IDLE);
  assign last_px   = (px_p0 == 4'd15) && (col_p0 == COL_W'(COLS-1)) && (row_p0 == ROW_W'(ROWS-1));

  always_comb begin
    px_nxt  = px_p0 + 4'd1;
    col_nxt = col_p0;
    row_nxt = row_p0;
    if (px_p0 == 4'd15) begin
      if (col_p0 == COL_W'(COLS-1)) begin
        col_nxt = '0;
        row_nxt = row_p0 + 1'b1;
      end else begin
        col_nxt = col_p0 + 1'b1;
      end
    end
  end

  // The pixel registered next is cell (0,0) px0 when entering DRAW, else the successor of the current one.
  always_comb begin
    tgt_px  = px_nxt;
    tgt_col = col_nxt;
    tgt_row = row_nxt;
    if (state == S_SETTLE) begin
      tgt_px  = '0;
      tgt_col = '0;
      tgt_row = '0;
    end
    cell_idx = IDX_W'(tgt_col) + IDX_W'(tgt_row) * IDX_W'(COLS);
  end

  // Stage boundary: counters and all outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      px_p0      <= '0;
      col_p0     <= '0;
      row_p0     <= '0;
      shift_en   <= 1'b0;
      plot_req   <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      shift_en   <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= tick_busy;
      case (state)
        S_IDLE: begin
          if (frame_tick) begin
            state    <= S_SHIFT;
            shift_en <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_SHIFT: state <= S_SETTLE;
        S_SETTLE: begin
          state    <= S_DRAW;
          px_p0    <= '0;
          col_p0   <= '0;
          row_p0   <= '0;
          plot_req <= 1'b1;
          x        <= pix_x(tgt_col, tgt_px);
          y        <= pix_y(tgt_row, tgt_px);
          colour   <= pick_colour(cell_data[cell_idx]);
        end
        S_DRAW: begin
          if (accept) begin
            if (last_px) begin
              state      <= S_DONE;
              plot_req   <= 1'b0;
              frame_done <= 1'b1;
              px_p0      <= '0;
              col_p0     <= '0;
              row_p0     <= '0;
              x          <= '0;
              y          <= '0;
              colour     <= '0;
            end else begin
              px_p0  <= px_nxt;
              col_p0 <= col_nxt;
              row_p0 <= row_nxt;
              x      <= pix_x(tgt_col, tgt_px);
              y      <= pix_y(tgt_row, tgt_px);
              colour <= pick_colour(cell_data[cell_idx]);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          plot_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef OVERRUN_CNT_EN
  logic [7:0] ovr_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ovr_cnt <= '0;
    else if (tick_busy && (ovr_cnt != 8'hFF))
      ovr_cnt <= ovr_cnt + 8'd1;
  end

  assign overrun_count = ovr_cnt;
`else
  assign overrun_count = 8'd0;
`endif

endmodule

// File: tb/tb_obstacle_frame_scheduler.sv
// Directed bench for obstacle_frame_scheduler: latency, pixel order/colour, handshake hold, overrun and reset.
module tb_obstacle_frame_scheduler;
  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam int NPIX = COLS * ROWS * 16;
`ifdef OVERRUN_CNT_EN
  localparam int OVR3   = 3;
  localparam int OVRSAT = 255;
`else
  localparam int OVR3   = 0;
  localparam int OVRSAT = 0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 frame_tick;
  logic                 vga_grant;
  logic [COLS*ROWS-1:0] cell_data;
  logic                 shift_en, plot_req, busy, frame_done, overrun;
  logic [7:0]           x, overrun_count;
  logic [6:0]           y;
  logic [2:0]           colour;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int k3, ovr_seen, sh_seen;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  obstacle_frame_scheduler dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .cell_data(cell_data),
    .vga_grant(vga_grant), .shift_en(shift_en), .plot_req(plot_req), .x(x), .y(y),
    .colour(colour), .busy(busy), .frame_done(frame_done), .overrun(overrun),
    .overrun_count(overrun_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mx(input int k);
    int px, b;
    px = k % 16;
    b  = (k / 16) % COLS;
    return 8'((156 + px / 4 - 4 * b) & 255);
  endfunction

  function automatic logic [6:0] my(input int k);
    return 7'(((k % 16) % 4 + 4 * (k / (16 * COLS))) & 127);
  endfunction

  function automatic logic [2:0] mc(input int k);
    return cell_data[(k / 16) % COLS + COLS * (k / (16 * COLS))] ? 3'b011 : 3'b000;
  endfunction

  // mode 0: grant always high; mode 1: grant 1,0,0,1 for 400 cycles, then high, tick on last accept
  task automatic run_frame(input int mode, output int accepts, output int bad, output int holdbad,
                           output int fgcnt, output int last_cyc);
    int k = 0;
    int budget = 0;
    logic held = 1'b0;
    logic g;
    logic [7:0] hx = '0;
    logic [6:0] hy = '0;
    logic [2:0] hc = '0;
    bad = 0; holdbad = 0; fgcnt = 0; last_cyc = -1;
    while (frame_done !== 1'b1 && budget < 60000) begin
      if (plot_req) begin
        if (held && (x !== hx || y !== hy || colour !== hc)) holdbad++;
        if (k < NPIX && (x !== mx(k) || y !== my(k) || colour !== mc(k))) bad++;
        hx = x; hy = y; hc = colour;
      end
      g = 1'b1;
      if (mode == 1 && budget < 400) g = (budget % 4 == 0) || (budget % 4 == 3);
      vga_grant = g;
      held = plot_req && !g;
      if (plot_req && g) begin
        if (colour === 3'b011) fgcnt++;
        if (k == NPIX - 1) begin
          chk("last_px_x", x, 3);
          chk("last_px_y", y, 119);
          last_cyc = cyc;
          if (mode == 1) frame_tick = 1'b1;
        end
        k++;
      end
      step();
      budget++;
    end
    frame_tick = 1'b0;
    accepts = k;
  endtask

  task automatic dstep();
    if (plot_req && vga_grant) k3++;
    step();
    if (overrun) ovr_seen++;
    if (shift_en) sh_seen++;
  endtask

  initial begin
    int t0, acc, bad, holdbad, fgcnt, last_cyc, guard;
    reset = 1'b1; frame_tick = 1'b0; vga_grant = 1'b0; cell_data = '0;
    step(); step();
    chk("rst_plot_req", plot_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_xy", {x, y, colour}, 0);
    chk("rst_ovr_cnt", overrun_count, 0);
    reset = 1'b0;
    step();

    // Frame 1: single set cell (r=2,b=5), grant held high
    cell_data[2 * COLS + 5] = 1'b1;
    frame_tick = 1'b1; t0 = cyc;
    step();
    frame_tick = 1'b0;
    chk("t1_shift_en", shift_en, 1);
    chk("t1_busy", busy, 1);
    chk("t1_plot_req", plot_req, 0);
    step();
    chk("t2_shift_en", shift_en, 0);
    chk("t2_plot_req", plot_req, 0);
    step();
    chk("t3_plot_req", plot_req, 1);
    chk("t3_x", x, 156);
    chk("t3_y", y, 0);
    run_frame(0, acc, bad, holdbad, fgcnt, last_cyc);
    chk("f1_frame_done", frame_done, 1);
    chk("f1_done_cycle", cyc - t0, 3 + 19200);
    chk("f1_done_after_last", cyc - last_cyc, 1);
    chk("f1_accepts", acc, 19200);
    chk("f1_pixel_errors", bad, 0);
    chk("f1_fg_pixels", fgcnt, 16);
    chk("f1_busy_in_done", busy, 1);
    chk("f1_plot_req_done", plot_req, 0);
    step();
    chk("f1_busy_drop", busy, 0);
    chk("f1_done_pulse", frame_done, 0);

    // Frame 2: dense pattern, grant toggling, tick coinciding with last accept
    for (int i = 0; i < COLS * ROWS; i++) cell_data[i] = (i % 7 == 0) || (i % 11 == 3);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step(); step();
    run_frame(1, acc, bad, holdbad, fgcnt, last_cyc);
    chk("f2_frame_done", frame_done, 1);
    chk("f2_accepts", acc, 19200);
    chk("f2_pixel_errors", bad, 0);
    chk("f2_hold_errors", holdbad, 0);
    chk("f2_overrun_last", overrun, 1);
    step();
    chk("f2_busy_drop", busy, 0);
    chk("f2_no_restart", shift_en, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Frame 3: overruns mid-DRAW, then reset at pixel 5000
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step(); step();
    vga_grant = 1'b1; k3 = 0; ovr_seen = 0; sh_seen = 0;
    repeat (100) dstep();
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1;
      dstep();
      frame_tick = 1'b0;
      chk("f3_ovr_pulse", overrun, 1);
      dstep();
      chk("f3_ovr_clear", overrun, 0);
    end
    chk("f3_ovr_seen3", ovr_seen, 3);
    chk("f3_ovr_count3", overrun_count, OVR3);
    frame_tick = 1'b1;
    repeat (300) dstep();
    frame_tick = 1'b0;
    dstep();
    chk("f3_ovr_seen303", ovr_seen, 303);
    chk("f3_ovr_count_sat", overrun_count, OVRSAT);
    chk("f3_no_reshift", sh_seen, 0);
    chk("f3_busy", busy, 1);
    guard = 0;
    while (k3 < 5000 && guard < 10000) begin
      dstep();
      guard++;
    end
    chk("f3_px5000_idx", k3, 5000);
    chk("f3_px5000_x", x, 30);
    chk("f3_px5000_y", y, 28);
    chk("f3_px5000_c", colour, mc(5000));
    reset = 1'b1;
    step();
    chk("f3_rst_outputs", {shift_en, plot_req, x, y, colour, frame_done, overrun, overrun_count}, 0);
    chk("f3_rst_busy", busy, 0);
    reset = 1'b0;
    step();
    chk("f3_idle_busy", busy, 0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("f3_restart_shift", shift_en, 1);
    step(); step();
    chk("f3_restart_req", plot_req, 1);
    chk("f3_restart_x", x, 156);
    chk("f3_restart_y", y, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
